// File: rtl/demux_prog_pkg.sv
// Shared types and constants for the demux select programmer.
package demux_prog_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_SEL,
    WR_SEL_B,
    WR_CMT,
    WR_CMT_B,
    RD_SEL,
    RD_SEL_R,
    DONE
  } state_t;

  localparam logic [7:0] REG_COMMIT  = 8'h00;
  localparam logic [7:0] REG_SELECT  = 8'h04;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/demux_prog_axil_wr.sv
// Single AXI4-Lite write: AW and W issued together, each dropping on its own
// handshake, then B accepted with bready and reported to the caller.
module demux_prog_axil_wr (
  input  logic        axil_aclk,
  input  logic        axil_areset,
  input  logic        start,
  input  logic [7:0]  start_addr,
  input  logic [31:0] start_data,
  output logic        addr_phase_done,
  output logic        resp_valid,
  output logic [1:0]  resp,
  output logic        m_axil_awvalid,
  input  logic        m_axil_awready,
  output logic [7:0]  m_axil_awaddr,
  output logic        m_axil_wvalid,
  input  logic        m_axil_wready,
  output logic [31:0] m_axil_wdata,
  input  logic        m_axil_bvalid,
  output logic        m_axil_bready,
  input  logic [1:0]  m_axil_bresp
);

  logic        awvalid_reg;
  logic        wvalid_reg;
  logic        bready_reg;
  logic        active_reg;
  logic [7:0]  addr_reg;
  logic [31:0] data_reg;
  logic        aw_left;
  logic        w_left;

  // A channel is still pending only while its valid is up and ready is not.
  assign aw_left         = awvalid_reg && !m_axil_awready;
  assign w_left          = wvalid_reg && !m_axil_wready;
  assign addr_phase_done = active_reg && !aw_left && !w_left;
  assign resp_valid      = bready_reg && m_axil_bvalid;
  assign resp            = m_axil_bresp;

  always_ff @(posedge axil_aclk) begin
    if (axil_areset) begin
      awvalid_reg <= 1'b0;
      wvalid_reg  <= 1'b0;
      bready_reg  <= 1'b0;
      active_reg  <= 1'b0;
      addr_reg    <= 8'h00;
      data_reg    <= 32'h0;
    end else begin
      if (resp_valid) begin
        bready_reg <= 1'b0;
      end
      if (start) begin
        awvalid_reg <= 1'b1;
        wvalid_reg  <= 1'b1;
        active_reg  <= 1'b1;
        addr_reg    <= start_addr;
        data_reg    <= start_data;
      end else begin
        if (awvalid_reg && m_axil_awready) begin
          awvalid_reg <= 1'b0;
        end
        if (wvalid_reg && m_axil_wready) begin
          wvalid_reg <= 1'b0;
        end
        if (addr_phase_done) begin
          active_reg <= 1'b0;
          bready_reg <= 1'b1;
        end
      end
    end
  end

  assign m_axil_awvalid = awvalid_reg;
  assign m_axil_awaddr  = addr_reg;
  assign m_axil_wvalid  = wvalid_reg;
  assign m_axil_wdata   = data_reg;
  assign m_axil_bready  = bready_reg;

endmodule

// File: rtl/demux_select_programmer.sv
// AXI4-Lite initiator writing SELECT then COMMIT to a demux control block.
// Optional SELECT readback/verify is enabled by defining DEMUX_PROG_READBACK_EN.
module demux_select_programmer
  import demux_prog_pkg::*;
#(
  parameter int         M_COUNT    = 2,
  parameter int         CL_M_COUNT = $clog2(M_COUNT),
  parameter logic [7:0] BASE_ADDR  = 8'h00
) (
  input  logic                  axil_aclk,
  input  logic                  axil_areset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [CL_M_COUNT-1:0] req_select,
  output logic                  done_valid,
  output logic                  done_error,
  output logic [1:0]            done_resp,
  output logic                  busy,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [7:0]            m_axil_awaddr,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  output logic [31:0]           m_axil_wdata,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  input  logic [1:0]            m_axil_bresp,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  output logic [7:0]            m_axil_araddr,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready,
  input  logic [31:0]           m_axil_rdata,
  input  logic [1:0]            m_axil_rresp
);

  state_t      state_reg;
  logic        req_ready_reg;
  logic        busy_reg;
  logic        done_valid_reg;
  logic        done_error_reg;
  logic [1:0]  done_resp_reg;

  logic        accept;
  logic        sel_ok;
  logic        wr_start;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_addr_done;
  logic        wr_resp_valid;
  logic [1:0]  wr_resp;

`ifdef DEMUX_PROG_READBACK_EN
  logic                  arvalid_reg;
  logic                  rready_reg;
  logic [7:0]            araddr_reg;
  logic [CL_M_COUNT-1:0] sel_reg;
`endif

  assign accept = (state_reg == IDLE) && req_valid && req_ready_reg;
  assign sel_ok = 32'(req_select) < 32'(M_COUNT);

  // The SELECT write launches on the accept edge; COMMIT launches on the OKAY B of SELECT.
  assign wr_start = (accept && sel_ok) ||
                    ((state_reg == WR_SEL_B) && wr_resp_valid && (wr_resp == RESP_OKAY));
  assign wr_addr  = (state_reg == IDLE) ? BASE_ADDR + REG_SELECT : BASE_ADDR + REG_COMMIT;
  assign wr_data  = (state_reg == IDLE) ? 32'(req_select) : 32'h1;

  demux_prog_axil_wr u_wr (
    .axil_aclk       (axil_aclk),
    .axil_areset     (axil_areset),
    .start           (wr_start),
    .start_addr      (wr_addr),
    .start_data      (wr_data),
    .addr_phase_done (wr_addr_done),
    .resp_valid      (wr_resp_valid),
    .resp            (wr_resp),
    .m_axil_awvalid  (m_axil_awvalid),
    .m_axil_awready  (m_axil_awready),
    .m_axil_awaddr   (m_axil_awaddr),
    .m_axil_wvalid   (m_axil_wvalid),
    .m_axil_wready   (m_axil_wready),
    .m_axil_wdata    (m_axil_wdata),
    .m_axil_bvalid   (m_axil_bvalid),
    .m_axil_bready   (m_axil_bready),
    .m_axil_bresp    (m_axil_bresp)
  );

  always_ff @(posedge axil_aclk) begin
    if (axil_areset) begin
      state_reg      <= IDLE;
      req_ready_reg  <= 1'b1;
      busy_reg       <= 1'b0;
      done_valid_reg <= 1'b0;
      done_error_reg <= 1'b0;
      done_resp_reg  <= RESP_OKAY;
`ifdef DEMUX_PROG_READBACK_EN
      arvalid_reg    <= 1'b0;
      rready_reg     <= 1'b0;
      araddr_reg     <= 8'h00;
      sel_reg        <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            req_ready_reg <= 1'b0;
            busy_reg      <= 1'b1;
`ifdef DEMUX_PROG_READBACK_EN
            sel_reg       <= req_select;
`endif
            // Out-of-range targets are rejected without touching the bus.
            if (!sel_ok) begin
              state_reg      <= DONE;
              done_valid_reg <= 1'b1;
              done_error_reg <= 1'b1;
              done_resp_reg  <= RESP_SLVERR;
            end else begin
              state_reg <= WR_SEL;
            end
          end
        end
        WR_SEL: begin
          if (wr_addr_done) state_reg <= WR_SEL_B;
        end
        WR_SEL_B: begin
          if (wr_resp_valid) begin
            if (wr_resp != RESP_OKAY) begin
              state_reg      <= DONE;
              done_valid_reg <= 1'b1;
              done_error_reg <= 1'b1;
              done_resp_reg  <= wr_resp;
            end else begin
              state_reg <= WR_CMT;
            end
          end
        end
        WR_CMT: begin
          if (wr_addr_done) state_reg <= WR_CMT_B;
        end
        WR_CMT_B: begin
          if (wr_resp_valid) begin
            if (wr_resp != RESP_OKAY) begin
              state_reg      <= DONE;
              done_valid_reg <= 1'b1;
              done_error_reg <= 1'b1;
              done_resp_reg  <= wr_resp;
            end else begin
`ifdef DEMUX_PROG_READBACK_EN
              state_reg   <= RD_SEL;
              arvalid_reg <= 1'b1;
              araddr_reg  <= BASE_ADDR + REG_SELECT;
`else
              state_reg      <= DONE;
              done_valid_reg <= 1'b1;
`endif
            end
          end
        end
`ifdef DEMUX_PROG_READBACK_EN
        RD_SEL: begin
          if (arvalid_reg && m_axil_arready) begin
            arvalid_reg <= 1'b0;
            rready_reg  <= 1'b1;
            state_reg   <= RD_SEL_R;
          end
        end
        RD_SEL_R: begin
          if (m_axil_rvalid && rready_reg) begin
            rready_reg     <= 1'b0;
            state_reg      <= DONE;
            done_valid_reg <= 1'b1;
            // A bus error wins over a data mismatch; a mismatch alone keeps resp OKAY.
            if (m_axil_rresp != RESP_OKAY) begin
              done_error_reg <= 1'b1;
              done_resp_reg  <= m_axil_rresp;
            end else if (m_axil_rdata != 32'(sel_reg)) begin
              done_error_reg <= 1'b1;
            end
          end
        end
`endif
        DONE: begin
          done_valid_reg <= 1'b0;
          done_error_reg <= 1'b0;
          done_resp_reg  <= RESP_OKAY;
          req_ready_reg  <= 1'b1;
          busy_reg       <= 1'b0;
          state_reg      <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef DEMUX_PROG_READBACK_EN
  assign m_axil_arvalid = arvalid_reg;
  assign m_axil_araddr  = araddr_reg;
  assign m_axil_rready  = rready_reg;
`else
  logic unused_rd;
  assign unused_rd      = ^{m_axil_arready, m_axil_rvalid, m_axil_rdata, m_axil_rresp};
  assign m_axil_arvalid = 1'b0;
  assign m_axil_araddr  = 8'h00;
  assign m_axil_rready  = 1'b0;
`endif

  assign req_ready  = req_ready_reg;
  assign busy       = busy_reg;
  assign done_valid = done_valid_reg;
  assign done_error = done_error_reg;
  assign done_resp  = done_resp_reg;

endmodule
